// File: rtl/cpack_9002_pkg.sv
// Shared constants, types and helpers for the cpack_9002 ADC channel packer.
// Optional build macro CPACK_9002_FLUSH_EN is consumed by the top, not here.
package cpack_9002_pkg;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 16;
    localparam int OUT_W     = NUM_LANES * LANE_W;
    localparam int HOLD_SLOTS = 7;

    // Lane positions on the concatenated ADC bus
    localparam int LANE_Q0 = 0;
    localparam int LANE_I0 = 1;
    localparam int LANE_Q1 = 2;
    localparam int LANE_I1 = 3;

    typedef logic [2:0]                          fill_t;
    typedef logic [LANE_W-1:0]                   sample_t;
    typedef logic [NUM_LANES-1:0][LANE_W-1:0]    lanes_t;

    function automatic fill_t popcount4(input logic [NUM_LANES-1:0] bits);
        fill_t cnt;
        cnt = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            cnt = cnt + fill_t'(bits[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/cpack_9002_gather.sv
// Combinational compaction of the enabled ADC lanes into a dense slot vector
// (lowest enabled lane in slot 0) plus the number of enabled lanes.
module cpack_9002_gather
    import cpack_9002_pkg::*;
(
    input  logic [OUT_W-1:0]     data,
    input  logic [NUM_LANES-1:0] enable,
    output lanes_t               slots,
    output fill_t                count
);

    always_comb begin
        fill_t idx;
        slots = '0;
        idx   = '0;
        for (int i = LANE_Q0; i <= LANE_I1; i++) begin
            if (enable[i]) begin
                slots[idx[1:0]] = data[i*LANE_W +: LANE_W];
                idx = idx + 3'd1;
            end
        end
    end

    assign count = popcount4(enable);

endmodule

// File: rtl/cpack_9002.sv
// ADC-side channel packer: packs enabled lanes into dense 64-bit DMA words.
// Define CPACK_9002_FLUSH_EN to emit zero-padded partial words on enable change.
module cpack_9002 #(
    parameter int NUM_LANES = 4,
    parameter int LANE_W    = 16,
    parameter int OUT_W     = 64
) (
    input  logic                 adc_clk,
    input  logic                 adc_resetn,
    input  logic [OUT_W-1:0]     adc_data,
    input  logic [NUM_LANES-1:0] adc_enable,
    input  logic [NUM_LANES-1:0] adc_valid,
    output logic [OUT_W-1:0]     packed_data,
    output logic                 packed_valid,
    output logic                 packed_sync,
    output logic                 partial_drop
);
    import cpack_9002_pkg::*;

    generate
        if (NUM_LANES != 4 || LANE_W != 16 || OUT_W != NUM_LANES * LANE_W) begin : g_bad_cfg
            $error("cpack_9002 supports only NUM_LANES=4, LANE_W=16, OUT_W=64");
        end
    endgenerate

    logic [NUM_LANES-1:0] enable_q_reg;
    fill_t                fill_reg;
    logic                 sync_pending_reg;
    sample_t              hold_reg [HOLD_SLOTS];
    logic [OUT_W-1:0]     packed_data_reg;
    logic                 packed_valid_reg;
    logic                 packed_sync_reg;

    lanes_t  gath_slots;
    fill_t   gath_count;
    fill_t   fill_sum;
    sample_t merged [HOLD_SLOTS];
    logic    enable_change;
    logic    beat;
    logic    word_done;

    cpack_9002_gather u_gather (
        .data   (adc_data),
        .enable (adc_enable),
        .slots  (gath_slots),
        .count  (gath_count)
    );

    assign enable_change = (adc_enable != enable_q_reg);
    assign beat          = (|(adc_valid & adc_enable)) && !enable_change;
    assign fill_sum      = fill_reg + gath_count;
    assign word_done     = fill_sum[2];

    // New samples land at slots fill..fill+N-1; everything else keeps held data
    genvar gi;
    generate
        for (gi = 0; gi < HOLD_SLOTS; gi++) begin : g_merge
            localparam fill_t SLOT = fill_t'(gi);
            logic [1:0] rel;
            assign rel = SLOT[1:0] - fill_reg[1:0];
            assign merged[gi] = (SLOT >= fill_reg && SLOT < fill_sum) ? gath_slots[rel] : hold_reg[gi];
        end
    endgenerate

`ifdef CPACK_9002_FLUSH_EN
    logic [OUT_W-1:0] flush_word;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_flush
            localparam fill_t SLOT = fill_t'(gi);
            assign flush_word[gi*LANE_W +: LANE_W] = (SLOT < fill_reg) ? hold_reg[gi] : '0;
        end
    endgenerate
`else
    logic partial_drop_reg;
`endif

    always_ff @(posedge adc_clk) begin
        if (!adc_resetn) begin
            enable_q_reg     <= '0;
            fill_reg         <= '0;
            sync_pending_reg <= 1'b1;
            packed_data_reg  <= '0;
            packed_valid_reg <= 1'b0;
            packed_sync_reg  <= 1'b0;
            for (int i = 0; i < HOLD_SLOTS; i++) begin
                hold_reg[i] <= '0;
            end
`ifndef CPACK_9002_FLUSH_EN
            partial_drop_reg <= 1'b0;
`endif
        end else begin
            enable_q_reg     <= adc_enable;
            packed_valid_reg <= 1'b0;
            packed_sync_reg  <= 1'b0;
`ifndef CPACK_9002_FLUSH_EN
            partial_drop_reg <= 1'b0;
`endif
            if (enable_change) begin
                // Lane mapping changed: the held partial word no longer lines up
                fill_reg         <= '0;
                sync_pending_reg <= 1'b1;
`ifdef CPACK_9002_FLUSH_EN
                if (fill_reg != '0) begin
                    packed_data_reg  <= flush_word;
                    packed_valid_reg <= 1'b1;
                    packed_sync_reg  <= sync_pending_reg;
                end
`else
                partial_drop_reg <= (fill_reg != '0);
`endif
            end else if (beat) begin
                if (word_done) begin
                    packed_data_reg  <= {merged[3], merged[2], merged[1], merged[0]};
                    packed_valid_reg <= 1'b1;
                    packed_sync_reg  <= sync_pending_reg;
                    sync_pending_reg <= 1'b0;
                    hold_reg[0]      <= merged[4];
                    hold_reg[1]      <= merged[5];
                    hold_reg[2]      <= merged[6];
                    for (int i = 3; i < HOLD_SLOTS; i++) begin
                        hold_reg[i] <= '0;
                    end
                    fill_reg <= {1'b0, fill_sum[1:0]};
                end else begin
                    for (int i = 0; i < HOLD_SLOTS; i++) begin
                        hold_reg[i] <= merged[i];
                    end
                    fill_reg <= fill_sum;
                end
            end
        end
    end

    assign packed_data  = packed_data_reg;
    assign packed_valid = packed_valid_reg;
    assign packed_sync  = packed_sync_reg;
`ifdef CPACK_9002_FLUSH_EN
    assign partial_drop = 1'b0;
`else
    assign partial_drop = partial_drop_reg;
`endif

endmodule

// File: tb/tb_cpack_9002.sv
// Directed, table-driven bench for cpack_9002: one row per clock of stimulus
// with hand-computed outputs expected right after that edge.
module tb_cpack_9002;

    logic        clk;
    logic        resetn;
    logic [63:0] adc_data;
    logic [3:0]  adc_enable;
    logic [3:0]  adc_valid;
    logic [63:0] packed_data;
    logic        packed_valid;
    logic        packed_sync;
    logic        partial_drop;

    int pass_cnt  = 0;
    int check_cnt = 0;

    cpack_9002 dut (
        .adc_clk      (clk),
        .adc_resetn   (resetn),
        .adc_data     (adc_data),
        .adc_enable   (adc_enable),
        .adc_valid    (adc_valid),
        .packed_data  (packed_data),
        .packed_valid (packed_valid),
        .packed_sync  (packed_sync),
        .partial_drop (partial_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rstn;
        logic [3:0]  en;
        logic [3:0]  val;
        logic [63:0] data;
        logic        exp_valid;
        logic        exp_sync;
        logic        exp_drop;
        logic        chk_data;
        logic [63:0] exp_data;
    } vec_t;

    localparam int NV = 22;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic rstn, input logic [3:0] en, input logic [3:0] val,
                                input logic [63:0] data, input logic ev, input logic es,
                                input logic ed, input logic cd, input logic [63:0] edata);
        vec_t v;
        v.rstn = rstn; v.en = en; v.val = val; v.data = data;
        v.exp_valid = ev; v.exp_sync = es; v.exp_drop = ed; v.chk_data = cd; v.exp_data = edata;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic apply(input vec_t v, input string nm);
        resetn     = v.rstn;
        adc_enable = v.en;
        adc_valid  = v.val;
        adc_data   = v.data;
        @(posedge clk);
        #1;
        chk({nm, ".valid"}, 64'(packed_valid), 64'(v.exp_valid));
        chk({nm, ".sync"},  64'(packed_sync),  64'(v.exp_sync));
        chk({nm, ".drop"},  64'(partial_drop), 64'(v.exp_drop));
        if (v.chk_data) chk({nm, ".data"}, packed_data, v.exp_data);
        $display("%s: en=%b val=%b data=%h -> valid=%b sync=%b drop=%b packed=%h",
                 nm, v.en, v.val, v.data, packed_valid, packed_sync, partial_drop, packed_data);
    endtask

    initial begin
        resetn = 1'b0; adc_enable = '0; adc_valid = '0; adc_data = '0;
        #2;

        tbl[0]  = mk(0, 4'hF, 4'hF, 64'h1111_2222_3333_4444, 0, 0, 0, 1, 64'h0);
        // First cycle out of reset sees an enable change: nothing happens
        tbl[1]  = mk(1, 4'hF, 4'h0, 64'h0, 0, 0, 0, 0, 64'h0);
        tbl[2]  = mk(1, 4'hF, 4'hF, 64'h0004_0003_0002_0001, 1, 1, 0, 1, 64'h0004_0003_0002_0001);
        tbl[3]  = mk(1, 4'hF, 4'hF, 64'h0004_0003_0002_0001, 1, 0, 0, 1, 64'h0004_0003_0002_0001);
        tbl[4]  = mk(1, 4'hF, 4'hF, 64'h0008_0007_0006_0005, 1, 0, 0, 1, 64'h0008_0007_0006_0005);
        tbl[5]  = mk(1, 4'hF, 4'h0, 64'h0, 0, 0, 0, 1, 64'h0008_0007_0006_0005);
        tbl[6]  = mk(1, 4'h3, 4'h0, 64'h0, 0, 0, 0, 0, 64'h0);
        tbl[7]  = mk(1, 4'h3, 4'h3, 64'hFFFF_EEEE_000B_000A, 0, 0, 0, 0, 64'h0);
        tbl[8]  = mk(1, 4'h3, 4'h3, 64'h1234_5678_000D_000C, 1, 1, 0, 1, 64'h000D_000C_000B_000A);
        tbl[9]  = mk(1, 4'h7, 4'h0, 64'h0, 0, 0, 0, 0, 64'h0);
        tbl[10] = mk(1, 4'h7, 4'h7, 64'hAAAA_0031_0021_0011, 0, 0, 0, 0, 64'h0);
        tbl[11] = mk(1, 4'h7, 4'h7, 64'hAAAA_0032_0022_0012, 1, 1, 0, 1, 64'h0012_0031_0021_0011);
        tbl[12] = mk(1, 4'h7, 4'h7, 64'hAAAA_0033_0023_0013, 1, 0, 0, 1, 64'h0023_0013_0032_0022);
        tbl[13] = mk(1, 4'h7, 4'h7, 64'hAAAA_0034_0024_0014, 1, 0, 0, 1, 64'h0034_0024_0014_0033);
        // Valid only on a disabled lane: ignored
        tbl[14] = mk(1, 4'h7, 4'h8, 64'h9999_0036_0026_0016, 0, 0, 0, 0, 64'h0);
        // One enabled lane valid: all enabled lanes taken
        tbl[15] = mk(1, 4'h7, 4'h4, 64'h5555_0035_0025_0015, 0, 0, 0, 0, 64'h0);
`ifdef CPACK_9002_FLUSH_EN
        tbl[16] = mk(1, 4'h1, 4'h0, 64'h0, 1, 0, 0, 1, 64'h0000_0035_0025_0015);
`else
        tbl[16] = mk(1, 4'h1, 4'h0, 64'h0, 0, 0, 1, 0, 64'h0);
`endif
        tbl[17] = mk(1, 4'h1, 4'h1, 64'h7777_6666_5555_0101, 0, 0, 0, 0, 64'h0);
        tbl[18] = mk(1, 4'h1, 4'h1, 64'h7777_6666_5555_0102, 0, 0, 0, 0, 64'h0);
        tbl[19] = mk(1, 4'h1, 4'h1, 64'h7777_6666_5555_0103, 0, 0, 0, 0, 64'h0);
`ifdef CPACK_9002_FLUSH_EN
        tbl[20] = mk(1, 4'hF, 4'h0, 64'h0, 1, 1, 0, 1, 64'h0000_0103_0102_0101);
`else
        tbl[20] = mk(1, 4'hF, 4'h0, 64'h0, 0, 0, 1, 0, 64'h0);
`endif
        tbl[21] = mk(1, 4'hF, 4'hF, 64'h0004_0003_0002_0001, 1, 1, 0, 1, 64'h0004_0003_0002_0001);

        for (int i = 0; i < NV; i++) begin
            apply(tbl[i], $sformatf("row%0d", i));
        end

        // Reset mid-word with fill=2: held samples must not leak into the next word
        apply(mk(1, 4'h3, 4'h0, 64'h0, 0, 0, 0, 0, 64'h0), "rst_a");
        apply(mk(1, 4'h3, 4'h3, 64'h0_0000_0022_0021, 0, 0, 0, 0, 64'h0), "rst_b");
        apply(mk(0, 4'h3, 4'h3, 64'h0_0000_0024_0023, 0, 0, 0, 1, 64'h0), "rst_c");
        apply(mk(1, 4'h3, 4'h3, 64'h0_0000_DEAD_BEEF, 0, 0, 0, 0, 64'h0), "rst_d");
        apply(mk(1, 4'h3, 4'h3, 64'h0_0000_0032_0031, 0, 0, 0, 0, 64'h0), "rst_e");
        apply(mk(1, 4'h3, 4'h3, 64'h0_0000_0034_0033, 1, 1, 0, 1, 64'h0034_0033_0032_0031), "rst_f");
        apply(mk(1, 4'h3, 4'h0, 64'h0, 0, 0, 0, 1, 64'h0034_0033_0032_0031), "rst_g");

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
